player_move_ctrl: RTL and testbench

- Sequences the player sprite for the stage screens.
- Converts held direction keys into step-wise position updates and walk-cycle frame codes on a per-frame tick.
- Drives player_x, player_y and player_state into the player sprite renderer.
- Each move is cleared with the map/collision block over a req/ack handshake before it is committed.

---
 rtl/player_move_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_player_move_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: turns held direction keys into stepped sprite moves for
// the stage screens. Each candidate position is cleared with the map block
// over mv_req/mv_ack before it is committed to player_x/player_y, and
// player_state carries the walk-cycle frame code (dir*3 + phase).
// Optional build macro: PLAYER_RUN_EN (key_run doubles the step and halves
// the walk-cycle period).
module player_move_ctrl #(
  parameter int STEP     = 2,
  parameter int ANIM_DIV = 8,
  parameter int X_MAX    = 300,
  parameter int Y_MAX    = 220,
  parameter int SPAWN_X  = 150,
  parameter int SPAWN_Y  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_run,
  output logic       mv_req,
  output logic [8:0] mv_x,
  output logic [8:0] mv_y,
  input  logic       mv_ack,
  input  logic       mv_ok,
  output logic [8:0] player_x,
  output logic [8:0] player_y,
  output logic [3:0] player_state,
  output logic       moving,
  output logic       fsm_dbg
);

  // Handshake: mv_req rises with mv_x/mv_y and all three stay stable until a
  // one-cycle mv_ack is sampled; mv_ok is meaningful only alongside mv_ack.
  // An ack with no request outstanding is ignored.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fsm_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [9:0] X_MAX_W   = 10'(X_MAX);
  localparam logic [9:0] Y_MAX_W   = 10'(Y_MAX);
  localparam logic [8:0] SPAWN_X_W = 9'(SPAWN_X);
  localparam logic [8:0] SPAWN_Y_W = 9'(SPAWN_Y);
  localparam logic [9:0] STEP_W    = 10'(STEP);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);
  localparam logic [3:0] CODE_DOWN1 = 4'd9;

  fsm_t       fsm_q;
  logic [3:0] prev_state_q;
  logic [8:0] x_q, y_q, mv_x_q, mv_y_q;
  logic       mv_req_q, moving_q;
  logic [1:0] dir_q, phase_q;
  logic [7:0] anim_cnt_q;
  logic [3:0] pstate_q;

  logic       in_stage, stage_entry, key_any;
  logic [1:0] key_dir;
  logic [9:0] x10, y10, tgt_x, tgt_y;
  logic       at_edge;
  logic [9:0] step_w;
  logic [7:0] anim_last;
  logic [7:0] anim_cnt_nx;
  logic [1:0] phase_nx;

  function automatic logic [3:0] frame_code(input logic [1:0] d, input logic [1:0] p);
    return ({2'b00, d} << 1) + {2'b00, d} + {2'b00, p};
  endfunction

`ifdef PLAYER_RUN_EN
  // Run modifier: double step, walk cycle twice as fast.
  always_comb begin
    step_w    = key_run ? (STEP_W << 1) : STEP_W;
    anim_last = key_run ? 8'(ANIM_DIV / 2 - 1) : ANIM_LAST;
  end
`else
  assign step_w    = STEP_W;
  assign anim_last = ANIM_LAST;
  logic unused_key_run;
  assign unused_key_run = key_run;
`endif

  assign in_stage    = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
  assign stage_entry = in_stage && (state != prev_state_q);
  assign key_any     = key_up | key_down | key_left | key_right;
  assign x10         = {1'b0, x_q};
  assign y10         = {1'b0, y_q};

  // Key priority: up > down > left > right.
  always_comb begin
    key_dir = DIR_RIGHT;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
  end

  // Candidate position, saturated to the legal grid in 10-bit arithmetic.
  always_comb begin
    tgt_x = x10;
    tgt_y = y10;
    case (key_dir)
      DIR_UP:    tgt_y = (y10 < step_w) ? 10'd0 : (y10 - step_w);
      DIR_DOWN:  tgt_y = ((y10 + step_w) > Y_MAX_W) ? Y_MAX_W : (y10 + step_w);
      DIR_LEFT:  tgt_x = (x10 < step_w) ? 10'd0 : (x10 - step_w);
      default:   tgt_x = ((x10 + step_w) > X_MAX_W) ? X_MAX_W : (x10 + step_w);
    endcase
    at_edge = (tgt_x == x10) && (tgt_y == y10);
  end

  logic unused_tgt_msb;
  assign unused_tgt_msb = tgt_x[9] ^ tgt_y[9];

  // Walk-cycle divider: phase advances once anim_cnt has sat at its last value.
  always_comb begin
    anim_cnt_nx = anim_cnt_q + 8'd1;
    phase_nx    = phase_q;
    if (anim_cnt_q >= anim_last) begin
      anim_cnt_nx = 8'd0;
      phase_nx    = (phase_q == 2'd2) ? 2'd0 : (phase_q + 2'd1);
    end
  end

  // Move FSM with registered outputs; leaving or re-entering a stage wins
  // over everything else and restores the spawn pose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      prev_state_q <= 4'd0;
      x_q          <= SPAWN_X_W;
      y_q          <= SPAWN_Y_W;
      mv_x_q       <= 9'd0;
      mv_y_q       <= 9'd0;
      mv_req_q     <= 1'b0;
      moving_q     <= 1'b0;
      dir_q        <= DIR_DOWN;
      phase_q      <= 2'd0;
      anim_cnt_q   <= 8'd0;
      pstate_q     <= CODE_DOWN1;
    end else begin
      prev_state_q <= state;
      if (!in_stage || stage_entry) begin
        fsm_q      <= S_IDLE;
        x_q        <= SPAWN_X_W;
        y_q        <= SPAWN_Y_W;
        mv_req_q   <= 1'b0;
        moving_q   <= 1'b0;
        dir_q      <= DIR_DOWN;
        phase_q    <= 2'd0;
        anim_cnt_q <= 8'd0;
        pstate_q   <= CODE_DOWN1;
      end else begin
        case (fsm_q)
          S_IDLE: begin
            if (tick) begin
              if (key_any) begin
                dir_q      <= key_dir;
                anim_cnt_q <= anim_cnt_nx;
                phase_q    <= phase_nx;
                pstate_q   <= frame_code(key_dir, phase_nx);
                if (!at_edge) begin
                  mv_x_q   <= tgt_x[8:0];
                  mv_y_q   <= tgt_y[8:0];
                  mv_req_q <= 1'b1;
                  moving_q <= 1'b1;
                  fsm_q    <= S_WAIT;
                end
              end else begin
                phase_q    <= 2'd0;
                anim_cnt_q <= 8'd0;
                pstate_q   <= frame_code(dir_q, 2'd0);
              end
            end
          end
          S_WAIT: begin
            if (mv_ack) begin
              mv_req_q <= 1'b0;
              moving_q <= 1'b0;
              fsm_q    <= S_IDLE;
              if (mv_ok) begin
                x_q <= mv_x_q;
                y_q <= mv_y_q;
              end
            end
          end
          default: fsm_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mv_req       = mv_req_q;
  assign mv_x         = mv_x_q;
  assign mv_y         = mv_y_q;
  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = pstate_q;
  assign moving       = moving_q;
  assign fsm_dbg      = (fsm_q == S_WAIT);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: reset, move/commit, refusal, key
// priority, edge saturation, walk-cycle timing and stage abort/re-entry.
module tb_player_move_ctrl;

  logic       clk, rst;
  logic [3:0] state;
  logic       tick, key_up, key_down, key_left, key_right, key_run;
  logic       mv_req, mv_ack, mv_ok, moving, fsm_dbg;
  logic [8:0] mv_x, mv_y, player_x, player_y;
  logic [3:0] player_state;

  int total = 0;
  int bad   = 0;
  int anim_ticks = 0;
  logic [3:0] exp_ps;

  player_move_ctrl dut (
    .clk(clk), .rst(rst), .state(state), .tick(tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_run(key_run), .mv_req(mv_req), .mv_x(mv_x), .mv_y(mv_y),
    .mv_ack(mv_ack), .mv_ok(mv_ok), .player_x(player_x), .player_y(player_y),
    .player_state(player_state), .moving(moving), .fsm_dbg(fsm_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Tick in IDLE; tracks the expected walk-cycle tick count.
  task automatic do_tick();
    if (key_up | key_down | key_left | key_right) anim_ticks++;
    else anim_ticks = 0;
    tick = 1'b1;
    next_cycle();
    tick = 1'b0;
  endtask

  task automatic do_ack(input logic ok);
    mv_ack = 1'b1; mv_ok = ok;
    next_cycle();
    mv_ack = 1'b0; mv_ok = 1'b0;
  endtask

  task automatic clear_keys();
    key_up = 0; key_down = 0; key_left = 0; key_right = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; state = 4'd0; tick = 0; clear_keys(); key_run = 0; mv_ack = 0; mv_ok = 0;
    repeat (3) next_cycle();
    total++; if (player_x !== 9'd150) begin bad++; $display("FAIL reset_x got=%0d exp=150", player_x); end
    total++; if (player_y !== 9'd200) begin bad++; $display("FAIL reset_y got=%0d exp=200", player_y); end
    total++; if (player_state !== 4'd9) begin bad++; $display("FAIL reset_ps got=%0d exp=9", player_state); end
    total++; if ({mv_req, moving, fsm_dbg} !== 3'b000) begin bad++; $display("FAIL reset_req got=%b exp=000", {mv_req, moving, fsm_dbg}); end
    total++; if ({mv_x, mv_y} !== 18'd0) begin bad++; $display("FAIL reset_mv got=%0d/%0d exp=0/0", mv_x, mv_y); end
    @(negedge clk); rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_in_wait();
    state = 4'd2;
    next_cycle();
    key_right = 1;
    do_tick();
    total++; if ({mv_req, fsm_dbg} !== 2'b11) begin bad++; $display("FAIL rw_req got=%b exp=11", {mv_req, fsm_dbg}); end
    #2 rst = 1'b1;
    #1;
    total++; if (mv_req !== 1'b0) begin bad++; $display("FAIL rw_async_req got=%b exp=0", mv_req); end
    total++; if ({player_x, player_y} !== {9'd150, 9'd200}) begin bad++; $display("FAIL rw_async_pos got=%0d,%0d exp=150,200", player_x, player_y); end
    total++; if (player_state !== 4'd9) begin bad++; $display("FAIL rw_async_ps got=%0d exp=9", player_state); end
    @(negedge clk); rst = 1'b0; clear_keys(); anim_ticks = 0;
    next_cycle();
  endtask

  task automatic test_move_right();
    key_right = 1;
    do_tick();
    total++; if ({mv_req, moving} !== 2'b11) begin bad++; $display("FAIL right_req got=%b exp=11", {mv_req, moving}); end
    total++; if ({mv_x, mv_y} !== {9'd152, 9'd200}) begin bad++; $display("FAIL right_mv got=%0d,%0d exp=152,200", mv_x, mv_y); end
    total++; if (player_state !== 4'd3) begin bad++; $display("FAIL right_ps got=%0d exp=3", player_state); end
    next_cycle();
    total++; if ({mv_req, mv_x, player_x} !== {1'b1, 9'd152, 9'd150}) begin bad++; $display("FAIL right_hold got=%b,%0d,%0d exp=1,152,150", mv_req, mv_x, player_x); end
    do_ack(1'b1);
    total++; if (player_x !== 9'd152) begin bad++; $display("FAIL right_commit got=%0d exp=152", player_x); end
    total++; if ({mv_req, moving, fsm_dbg} !== 3'b000) begin bad++; $display("FAIL right_done got=%b exp=000", {mv_req, moving, fsm_dbg}); end
    clear_keys();
  endtask

  task automatic test_refused_up();
    key_up = 1;
    do_tick();
    total++; if ({mv_req, mv_y} !== {1'b1, 9'd198}) begin bad++; $display("FAIL up_req got=%b,%0d exp=1,198", mv_req, mv_y); end
    total++; if (player_state !== 4'd0) begin bad++; $display("FAIL up_ps got=%0d exp=0", player_state); end
    tick = 1; next_cycle(); tick = 0;
    total++; if ({mv_req, mv_y} !== {1'b1, 9'd198}) begin bad++; $display("FAIL up_waittick got=%b,%0d exp=1,198", mv_req, mv_y); end
    tick = 1; mv_ack = 1; mv_ok = 0;
    next_cycle();
    tick = 0; mv_ack = 0;
    total++; if ({mv_req, player_y} !== {1'b0, 9'd200}) begin bad++; $display("FAIL up_refuse got=%b,%0d exp=0,200", mv_req, player_y); end
    next_cycle();
    total++; if (mv_req !== 1'b0) begin bad++; $display("FAIL up_noreq2 got=%b exp=0", mv_req); end
    clear_keys();
    mv_ack = 1; mv_ok = 1; next_cycle(); mv_ack = 0; mv_ok = 0;
    total++; if ({mv_req, player_x, player_y} !== {1'b0, 9'd152, 9'd200}) begin bad++; $display("FAIL idle_ack got=%b,%0d,%0d exp=0,152,200", mv_req, player_x, player_y); end
  endtask

  task automatic test_priority();
    key_down = 1; key_left = 1;
    do_tick();
    total++; if ({mv_x, mv_y, player_state} !== {9'd152, 9'd202, 4'd9}) begin bad++; $display("FAIL prio_dl got=%0d,%0d,%0d exp=152,202,9", mv_x, mv_y, player_state); end
    do_ack(1'b0);
    key_up = 1; key_right = 1;
    do_tick();
    total++; if ({mv_x, mv_y, player_state} !== {9'd152, 9'd198, 4'd0}) begin bad++; $display("FAIL prio_all got=%0d,%0d,%0d exp=152,198,0", mv_x, mv_y, player_state); end
    do_ack(1'b0);
    clear_keys();
    do_tick();
    total++; if (player_state !== 4'd0) begin bad++; $display("FAIL release_ps got=%0d exp=0", player_state); end
  endtask

  task automatic test_left_edge();
    key_left = 1;
    for (int i = 0; i < 76; i++) begin
      do_tick();
      if (mv_req) do_ack(1'b1);
    end
    total++; if (player_x !== 9'd0) begin bad++; $display("FAIL left_walk got=%0d exp=0", player_x); end
    do_tick();
    exp_ps = 4'(6 + (anim_ticks / 8) % 3);
    total++; if ({mv_req, moving} !== 2'b00) begin bad++; $display("FAIL left_edge_req got=%b exp=00", {mv_req, moving}); end
    total++; if (player_state !== exp_ps) begin bad++; $display("FAIL left_edge_ps got=%0d exp=%0d", player_state, exp_ps); end
    next_cycle();
    total++; if ({mv_req, player_x} !== {1'b0, 9'd0}) begin bad++; $display("FAIL left_edge_hold got=%b,%0d exp=0,0", mv_req, player_x); end
    clear_keys();
  endtask

  task automatic test_down_edge();
    do_tick();
    total++; if (player_state !== 4'd6) begin bad++; $display("FAIL down_release got=%0d exp=6", player_state); end
    key_down = 1;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      if (i == 9) begin
        total++; if ({mv_req, mv_y} !== {1'b1, 9'd220}) begin bad++; $display("FAIL down_last got=%b,%0d exp=1,220", mv_req, mv_y); end
      end
      if (mv_req) do_ack(1'b1);
    end
    do_tick();
    total++; if ({mv_req, player_y} !== {1'b0, 9'd220}) begin bad++; $display("FAIL down_edge got=%b,%0d exp=0,220", mv_req, player_y); end
    total++; if (player_state !== 4'd10) begin bad++; $display("FAIL down_edge_ps got=%0d exp=10", player_state); end
    clear_keys();
  endtask

  task automatic test_anim();
    do_tick();
    total++; if (player_state !== 4'd9) begin bad++; $display("FAIL anim_release got=%0d exp=9", player_state); end
    key_up = 1;
    for (int k = 1; k <= 24; k++) begin
      do_tick();
      exp_ps = (k < 8) ? 4'd0 : (k < 16) ? 4'd1 : (k < 24) ? 4'd2 : 4'd0;
      total++; if (player_state !== exp_ps) begin bad++; $display("FAIL anim_t%0d got=%0d exp=%0d", k, player_state, exp_ps); end
      if (mv_req) do_ack(1'b1);
    end
    total++; if (player_y !== 9'd172) begin bad++; $display("FAIL anim_y got=%0d exp=172", player_y); end
    clear_keys();
    do_tick();
    total++; if (player_state !== 4'd0) begin bad++; $display("FAIL anim_stop got=%0d exp=0", player_state); end
  endtask

  task automatic test_abort();
    key_right = 1;
    do_tick();
    total++; if ({mv_req, mv_x} !== {1'b1, 9'd2}) begin bad++; $display("FAIL abort_req got=%b,%0d exp=1,2", mv_req, mv_x); end
    state = 4'd8;
    next_cycle();
    total++; if ({mv_req, moving, fsm_dbg} !== 3'b000) begin bad++; $display("FAIL abort_drop got=%b exp=000", {mv_req, moving, fsm_dbg}); end
    do_ack(1'b1);
    total++; if ({player_x, player_y, player_state} !== {9'd150, 9'd200, 4'd9}) begin bad++; $display("FAIL abort_late got=%0d,%0d,%0d exp=150,200,9", player_x, player_y, player_state); end
    clear_keys();
    state = 4'd4;
    next_cycle();
    anim_ticks = 0;
    total++; if ({mv_req, player_x, player_y, player_state} !== {1'b0, 9'd150, 9'd200, 4'd9}) begin bad++; $display("FAIL stage2_entry got=%b,%0d,%0d,%0d exp=0,150,200,9", mv_req, player_x, player_y, player_state); end
    key_right = 1;
    do_tick();
    total++; if ({mv_req, mv_x, player_state} !== {1'b1, 9'd152, 4'd3}) begin bad++; $display("FAIL stage2_move got=%b,%0d,%0d exp=1,152,3", mv_req, mv_x, player_state); end
    do_ack(1'b1);
    clear_keys();
    total++; if (player_x !== 9'd152) begin bad++; $display("FAIL stage2_commit got=%0d exp=152", player_x); end
    state = 4'd5; next_cycle();
    state = 4'd6; next_cycle();
    total++; if ({player_x, player_y, player_state} !== {9'd150, 9'd200, 4'd9}) begin bad++; $display("FAIL stage3_entry got=%0d,%0d,%0d exp=150,200,9", player_x, player_y, player_state); end
  endtask

  initial begin
    test_reset();
    test_reset_in_wait();
    test_move_right();
    test_refused_up();
    test_priority();
    test_left_edge();
    test_down_edge();
    test_anim();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
